hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter CNT_W, default 2: width of each per-register pending-write counter; maximum in-flight writes per register is 2^CNT_W-1.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 id_valid  in  1  decoded instruction present in ID.
REQ-005 id_src1  in  4  first source register (Rn).
REQ-006 id_src2  in  4  second source register (Rm, or Rd for stores).
REQ-007 id_two_src  in  1  id_src2 is read by the instruction.
REQ-008 id_wb_en  in  1  instruction writes id_dest.
REQ-009 id_dest  in  4  destination register.
REQ-010 id_s  in  1  instruction updates status flags.
REQ-011 id_use_flags  in  1  condition field is not AL (instruction reads flags).
REQ-012 flush  in  1  instruction in ID is squashed (taken branch); it is never issued.
REQ-013 kill_valid / kill_dest / kill_s  in  1/4/1  an issued instruction is squashed before writeback; its pending write (if kill_valid) and flag update (if kill_s) are cancelled.
REQ-014 wb_en / wb_dest  in  1/4  register-file write this cycle (writeback stage).
REQ-015 flags_wr  in  1  status register updated this cycle.
REQ-016 drain_req  in  1  request to empty the pipeline of pending writes.
REQ-017 hazard  out  1  ID must stall this cycle.
REQ-018 issue  out  1  instruction leaves ID this cycle.
REQ-019 pending  out  16  bit i set when counter i is nonzero.
REQ-020 drain_done  out  1  no pending register or flag writes and issue blocked.
REQ-021 err  out  1  sticky underflow error.

Function
REQ-022 Keep 16 CNT_W-bit counters cnt[0..15] plus a CNT_W-bit flag counter fcnt.
REQ-023 Retire-bypass: for hazard evaluation, a register with cnt==1 and wb_en & wb_dest equal to it this cycle is treated as not pending (register file writes on negedge, so the read is valid); same rule for fcnt==1 with flags_wr.
REQ-024 hazard = id_valid & ~flush & (src1 pending | (id_two_src & src2 pending) | (id_use_flags & flags pending) | (id_wb_en & cnt[id_dest] saturated) | (id_s & fcnt saturated) | state!=RUN), combinational.
REQ-025 issue = id_valid & ~flush & ~hazard, combinational.
REQ-026 On posedge, cnt[r] next = cnt[r] + inc - dec, where inc = issue & id_wb_en & id_dest==r, dec = (wb_en & wb_dest==r) + (kill_valid & kill_dest==r); fcnt likewise with id_s, flags_wr, kill_s.
REQ-027 Simultaneous inc and dec of one counter leaves it unchanged; a dec of 2 in one cycle is legal.
REQ-028 Underflow (net result below 0) clamps the counter at 0 and sets err; err clears only on rst.
REQ-029 Overflow is impossible: saturation stalls issue per REQ-024.
REQ-030 FSM states RUN, DRAIN, DRAINED; RUN->DRAIN on drain_req; DRAIN->DRAINED when all counters and fcnt are 0 (evaluated on next-state values); DRAINED->RUN when drain_req deasserts; DRAIN->RUN if drain_req deasserts before empty.
REQ-031 drain_done = (state==DRAINED), registered.
REQ-032 flush has priority over hazard: when flush=1, hazard=0 and issue=0.

Reset
REQ-033 On rst: all counters and fcnt 0, state RUN, pending=0, drain_done=0, err=0; hazard and issue follow REQ-024/025 from reset state.
REQ-034 Assertion of rst mid-drain or with in-flight writes discards all state immediately, without waiting for a clock edge.

Verification
REQ-035 Issue ADD r3 (wb_en, dest 3); next cycle instruction with src1=3 -> hazard=1 until wb_en/wb_dest=3 cycle, in which hazard=0, issue=1 (bypass).
REQ-036 Issue three writes to r5 with CNT_W=2 -> cnt[5]=3, a fourth write to r5 gets hazard=1 while unrelated sources read freely.
REQ-037 Same cycle: issue write r7 and wb_en to r7 with cnt[7]=1 -> cnt[7] stays 1, pending[7]=1.
REQ-038 wb_en to r2 with cnt[2]=0 -> cnt[2] stays 0, err=1 and remains 1 until rst.
REQ-039 CMP (id_s) issued, then BNE (id_use_flags) -> hazard=1 until flags_wr; kill_s on the CMP instead clears fcnt and releases the stall.
REQ-040 drain_req with r1,r4 pending -> state DRAIN, issue=0; after both writebacks drain_done=1; drop drain_req -> RUN next cycle, drain_done=0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Issue/writeback/drain signal bundle between ID-stage control and the hazard scoreboard.
// Purely structural; no timing of its own.
// The scoreboard side (slave) computes hazard/issue combinationally from these inputs.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        id_wb_en;
  logic [3:0]  id_dest;
  logic        id_s;
  logic        id_use_flags;
  logic        flush;
  logic        kill_valid;
  logic [3:0]  kill_dest;
  logic        kill_s;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic        flags_wr;
  logic        drain_req;
  logic        hazard;
  logic        issue;
  logic [15:0] pending;
  logic        drain_done;
  logic        err;

  modport master (
    output id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_s,
           id_use_flags, flush, kill_valid, kill_dest, kill_s, wb_en, wb_dest,
           flags_wr, drain_req,
    input  hazard, issue, pending, drain_done, err
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_two_src, id_wb_en, id_dest, id_s,
           id_use_flags, flush, kill_valid, kill_dest, kill_s, wb_en, wb_dest,
           flags_wr, drain_req,
    output hazard, issue, pending, drain_done, err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard that stalls ID on RAW/flag hazards and supports pipeline drain.
// Latency: hazard/issue are combinational; counters and drain state update on the next posedge.
// Backpressure: hazard holds ID when a source/flag is pending, a counter is saturated, or a drain is active.
module hazard_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt      [16];
  logic [CNT_W-1:0] cnt_nxt  [16];
  logic [CNT_W-1:0] fcnt;
  logic [CNT_W-1:0] fcnt_nxt;
  logic             underflow;
  logic             all_zero_nxt;
  logic             err_q;
  state_t           state;
  state_t           state_nxt;

  logic src1_pend, src2_pend, flag_pend, dest_sat, flag_sat;

  // Apply +inc -dec to one counter; MSB of the result flags an underflow (value clamped to 0).
  function automatic logic [CNT_W:0] step(input logic [CNT_W-1:0] cur,
                                          input logic inc,
                                          input logic [1:0] dec);
    logic [CNT_W+1:0] sum;
    logic [CNT_W+1:0] dec_w;
    sum   = {2'b00, cur} + {{(CNT_W+1){1'b0}}, inc};
    dec_w = {{CNT_W{1'b0}}, dec};
    if (sum < dec_w) begin
      step = {1'b1, {CNT_W{1'b0}}};
    end else begin
      sum  = sum - dec_w;
      step = {1'b0, sum[CNT_W-1:0]};
    end
  endfunction

  // Hazard detection; a counter at 1 retiring this cycle is readable because the RF writes on negedge.
  always_comb begin
    src1_pend = (cnt[sb.id_src1] != '0) &&
                !((cnt[sb.id_src1] == CNT_ONE) && sb.wb_en && (sb.wb_dest == sb.id_src1));
    src2_pend = (cnt[sb.id_src2] != '0) &&
                !((cnt[sb.id_src2] == CNT_ONE) && sb.wb_en && (sb.wb_dest == sb.id_src2));
    flag_pend = (fcnt != '0) && !((fcnt == CNT_ONE) && sb.flags_wr);
    dest_sat  = (cnt[sb.id_dest] == CNT_MAX);
    flag_sat  = (fcnt == CNT_MAX);
    sb.hazard = sb.id_valid && !sb.flush &&
                (src1_pend || (sb.id_two_src && src2_pend) ||
                 (sb.id_use_flags && flag_pend) || (sb.id_wb_en && dest_sat) ||
                 (sb.id_s && flag_sat) || (state != RUN));
    sb.issue  = sb.id_valid && !sb.flush && !sb.hazard;
  end

  // Next counter values from issue increments and writeback/kill decrements.
  always_comb begin
    logic [CNT_W:0] res;
    underflow    = 1'b0;
    all_zero_nxt = 1'b1;
    for (int r = 0; r < 16; r++) begin
      res = step(cnt[r],
                 sb.issue && sb.id_wb_en && (sb.id_dest == 4'(r)),
                 {1'b0, sb.wb_en && (sb.wb_dest == 4'(r))} +
                 {1'b0, sb.kill_valid && (sb.kill_dest == 4'(r))});
      cnt_nxt[r] = res[CNT_W-1:0];
      underflow  = underflow | res[CNT_W];
      if (res[CNT_W-1:0] != '0) all_zero_nxt = 1'b0;
    end
    res       = step(fcnt, sb.issue && sb.id_s,
                     {1'b0, sb.flags_wr} + {1'b0, sb.kill_s});
    fcnt_nxt  = res[CNT_W-1:0];
    underflow = underflow | res[CNT_W];
    if (res[CNT_W-1:0] != '0) all_zero_nxt = 1'b0;
  end

  // Drain FSM next-state: empty is judged on post-update counter values.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (sb.drain_req) state_nxt = DRAIN;
      DRAIN:   if (!sb.drain_req) state_nxt = RUN;
               else if (all_zero_nxt) state_nxt = DRAINED;
      DRAINED: if (!sb.drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // State register, counters and sticky underflow error; reset discards everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) cnt[r] <= '0;
      fcnt  <= '0;
      state <= RUN;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < 16; r++) cnt[r] <= cnt_nxt[r];
      fcnt  <= fcnt_nxt;
      state <= state_nxt;
      err_q <= err_q | underflow;
    end
  end

  // Status outputs derived directly from registered state.
  always_comb begin
    for (int r = 0; r < 16; r++) sb.pending[r] = (cnt[r] != '0);
    sb.drain_done = (state == DRAINED);
    sb.err        = err_q;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: RAW bypass, saturation, same-cycle inc/dec,
// flag hazards with kill, drain FSM, flush priority, sticky underflow and async reset.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  hazard_scoreboard_if sb ();

  hazard_scoreboard #(.CNT_W(2)) dut (.clk(clk), .rst(rst), .sb(sb));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    sb.id_valid = 0; sb.id_src1 = 0; sb.id_src2 = 0; sb.id_two_src = 0;
    sb.id_wb_en = 0; sb.id_dest = 0; sb.id_s = 0; sb.id_use_flags = 0;
    sb.flush = 0; sb.kill_valid = 0; sb.kill_dest = 0; sb.kill_s = 0;
    sb.wb_en = 0; sb.wb_dest = 0; sb.flags_wr = 0; sb.drain_req = 0;
  endtask

  // advance one clock; inputs change and outputs are sampled 1 time unit after posedge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d);
    sb.id_valid = 1; sb.id_wb_en = 1; sb.id_dest = d;
  endtask

  initial begin
    idle();
    #2;
    chk("rst_pending", sb.pending, 16'h0);
    chk("rst_drain_done", {15'b0, sb.drain_done}, 16'h0);
    chk("rst_err", {15'b0, sb.err}, 16'h0);
    chk("rst_hazard", {15'b0, sb.hazard}, 16'h0);
    chk("rst_issue", {15'b0, sb.issue}, 16'h0);
    cyc();
    rst = 0;
    cyc();

    // RAW on r3 with writeback bypass
    wr(4'd3); #1;
    chk("add_issue", {15'b0, sb.issue}, 16'h1);
    cyc(); idle();
    chk("r3_pending", sb.pending, 16'h0008);
    sb.id_valid = 1; sb.id_src1 = 3; #1;
    chk("raw_hazard", {15'b0, sb.hazard}, 16'h1);
    chk("raw_no_issue", {15'b0, sb.issue}, 16'h0);
    cyc();
    chk("raw_hazard_hold", {15'b0, sb.hazard}, 16'h1);
    sb.wb_en = 1; sb.wb_dest = 3; #1;
    chk("bypass_hazard", {15'b0, sb.hazard}, 16'h0);
    chk("bypass_issue", {15'b0, sb.issue}, 16'h1);
    cyc(); idle();
    chk("r3_retired", sb.pending, 16'h0);

    // saturation of r5 at three in-flight writes
    wr(4'd5); cyc(); cyc(); cyc();
    chk("r5_pending", sb.pending, 16'h0020);
    #1;
    chk("sat_hazard", {15'b0, sb.hazard}, 16'h1);
    idle(); sb.id_valid = 1; sb.id_src1 = 2; sb.id_src2 = 6; sb.id_two_src = 1; #1;
    chk("unrelated_issue", {15'b0, sb.issue}, 16'h1);
    idle(); sb.id_valid = 1; sb.id_two_src = 1; sb.id_src2 = 5; sb.wb_en = 1; sb.wb_dest = 5; #1;
    chk("cnt3_not_bypassed", {15'b0, sb.hazard}, 16'h1);
    idle(); sb.wb_en = 1; sb.wb_dest = 5;
    cyc(); cyc();
    chk("r5_one_left", sb.pending, 16'h0020);
    cyc(); idle();
    chk("r5_drained", sb.pending, 16'h0);

    // same-cycle increment and decrement of r7
    wr(4'd7); cyc();
    wr(4'd7); sb.wb_en = 1; sb.wb_dest = 7; cyc(); idle();
    chk("r7_still_pending", sb.pending, 16'h0080);
    sb.wb_en = 1; sb.wb_dest = 7; cyc(); idle();
    chk("r7_count_was_one", sb.pending, 16'h0);
    chk("r7_no_err", {15'b0, sb.err}, 16'h0);

    // flag hazard released by flags_wr, then by kill_s
    sb.id_valid = 1; sb.id_s = 1; cyc(); idle();
    sb.id_valid = 1; sb.id_use_flags = 1; #1;
    chk("bne_hazard", {15'b0, sb.hazard}, 16'h1);
    sb.flags_wr = 1; #1;
    chk("flags_bypass_issue", {15'b0, sb.issue}, 16'h1);
    cyc(); idle();
    sb.id_valid = 1; sb.id_s = 1; cyc(); idle();
    sb.id_valid = 1; sb.id_use_flags = 1; sb.kill_s = 1; #1;
    chk("kill_cycle_hazard", {15'b0, sb.hazard}, 16'h1);
    cyc(); sb.kill_s = 0; #1;
    chk("after_kill_hazard", {15'b0, sb.hazard}, 16'h0);
    chk("after_kill_issue", {15'b0, sb.issue}, 16'h1);
    idle();

    // flush priority: no hazard, no issue, no counter update
    sb.id_valid = 1; sb.id_src1 = 0; sb.id_wb_en = 1; sb.id_dest = 9; sb.flush = 1; #1;
    chk("flush_issue", {15'b0, sb.issue}, 16'h0);
    chk("flush_hazard", {15'b0, sb.hazard}, 16'h0);
    cyc(); idle();
    chk("flush_no_pending", sb.pending, 16'h0);

    // drain with r1 and r4 in flight
    wr(4'd1); cyc(); wr(4'd4); cyc(); idle();
    chk("drain_pre_pending", sb.pending, 16'h0012);
    sb.drain_req = 1; cyc();
    sb.id_valid = 1; #1;
    chk("drain_hazard", {15'b0, sb.hazard}, 16'h1);
    chk("drain_no_issue", {15'b0, sb.issue}, 16'h0);
    sb.wb_en = 1; sb.wb_dest = 1; cyc();
    chk("drain_not_done", {15'b0, sb.drain_done}, 16'h0);
    sb.wb_dest = 4; cyc(); sb.wb_en = 0;
    chk("drain_done", {15'b0, sb.drain_done}, 16'h1);
    chk("drained_no_issue", {15'b0, sb.issue}, 16'h0);
    sb.drain_req = 0; cyc();
    chk("run_drain_done", {15'b0, sb.drain_done}, 16'h0);
    chk("run_issue", {15'b0, sb.issue}, 16'h1);
    idle();

    // double decrement in one cycle is legal
    wr(4'd8); cyc(); wr(4'd8); cyc(); idle();
    sb.wb_en = 1; sb.wb_dest = 8; sb.kill_valid = 1; sb.kill_dest = 8; cyc(); idle();
    chk("dec2_pending", sb.pending, 16'h0);
    chk("dec2_no_err", {15'b0, sb.err}, 16'h0);

    // underflow on r2 is sticky
    sb.wb_en = 1; sb.wb_dest = 2; cyc(); idle();
    chk("uf_err", {15'b0, sb.err}, 16'h1);
    chk("uf_clamp", sb.pending, 16'h0);
    cyc(); cyc();
    chk("uf_err_sticky", {15'b0, sb.err}, 16'h1);

    // asynchronous reset with a write in flight, mid-cycle
    wr(4'd10); cyc(); idle();
    chk("r10_pending", sb.pending, 16'h0400);
    #2 rst = 1; #1;
    chk("arst_pending", sb.pending, 16'h0);
    chk("arst_err", {15'b0, sb.err}, 16'h0);
    cyc(); rst = 0; cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
